// File: rtl/dram_port_arbiter_if.sv
// dram_port_arbiter_if
//   Bundles the requester-side handshake and the DRAM-side bus of the
//   DRAM port arbiter.
//
//   Handshake semantics: a requester raises rd_req / wr_req and holds its
//   base address stable until it sees the matching one-cycle grant pulse.
//   During a write burst the requester drives one beat on wr_data per cycle.
//   wr_data_ack high means that beat is consumed this cycle, so the next
//   beat goes on the bus in the following cycle. Read data is qualified by
//   rd_data_valid. There is no back-pressure from the DRAM side.
//
//   Modports:
//     slave  - the arbiter: takes requests, drives grants and the DRAM bus
//     master - the requester/memory side view (inverse directions)
interface dram_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_grant;
    logic              wr_grant;
    logic              wr_data_ack;
    logic              rd_data_valid;
    logic              mem_ren;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_raddr;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_grant, wr_grant, wr_data_ack, rd_data_valid,
               mem_ren, mem_wen, mem_raddr, mem_waddr, mem_wdata, busy
    );

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_grant, wr_grant, wr_data_ack, rd_data_valid,
               mem_ren, mem_wen, mem_raddr, mem_waddr, mem_wdata, busy
    );
endinterface

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter
//   Arbitrates a single DRAM port between a read requester (ifmap FIFO fill)
//   and a write requester (pooled-result drain). Each grant runs one burst
//   of BURST_LEN beats at consecutive (wrapping) word addresses, then the
//   FSM returns to IDLE for at least one cycle. Simultaneous requests are
//   resolved round-robin using last_wr.
//
//   Ports:
//     clk       - single clock, rising edge
//     rst       - asynchronous active-low reset
//     bus       - dram_port_arbiter_if.slave (requests, grants, DRAM bus)
//     state_dbg - current FSM state (0 IDLE, 1 READ, 2 WRITE)
module dram_port_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    dram_port_arbiter_if.slave   bus,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    // 4 bits covers the full legal burst range of 1..16 beats.
    localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

    state_t            state;
    logic [3:0]        beat;
    logic              last_wr;
    logic [ADDR_W-1:0] cur_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            beat              <= '0;
            last_wr           <= 1'b1;
            cur_addr          <= '0;
            bus.rd_grant      <= 1'b0;
            bus.wr_grant      <= 1'b0;
            bus.rd_data_valid <= 1'b0;
            bus.mem_ren       <= 1'b0;
            bus.mem_wen       <= 1'b0;
            bus.mem_raddr     <= '0;
            bus.mem_waddr     <= '0;
            bus.mem_wdata     <= '0;
        end else begin
            // Pulses default low; addresses/data hold their last value.
            bus.rd_grant      <= 1'b0;
            bus.wr_grant      <= 1'b0;
            bus.mem_ren       <= 1'b0;
            bus.mem_wen       <= 1'b0;
            // DRAM read latency is one cycle.
            bus.rd_data_valid <= bus.mem_ren;

            case (state)
                IDLE: begin
                    // With both pending, read wins only if write went last.
                    if (bus.rd_req && (!bus.wr_req || last_wr)) begin
                        state        <= READ;
                        bus.rd_grant <= 1'b1;
                        last_wr      <= 1'b0;
                        cur_addr     <= bus.rd_addr;
                        beat         <= '0;
                    end else if (bus.wr_req) begin
                        state        <= WRITE;
                        bus.wr_grant <= 1'b1;
                        last_wr      <= 1'b1;
                        cur_addr     <= bus.wr_addr;
                        beat         <= '0;
                    end
                end

                READ: begin
                    bus.mem_ren   <= 1'b1;
                    bus.mem_raddr <= cur_addr;
                    // Natural ADDR_W-bit overflow gives the required wrap.
                    cur_addr      <= cur_addr + ADDR_W'(1);
                    if (beat == LAST_BEAT) begin
                        state <= IDLE;
                        beat  <= '0;
                    end else begin
                        beat  <= beat + 4'd1;
                    end
                end

                WRITE: begin
                    bus.mem_wen   <= 1'b1;
                    bus.mem_waddr <= cur_addr;
                    bus.mem_wdata <= bus.wr_data;
                    cur_addr      <= cur_addr + ADDR_W'(1);
                    if (beat == LAST_BEAT) begin
                        state <= IDLE;
                        beat  <= '0;
                    end else begin
                        beat  <= beat + 4'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    beat  <= '0;
                end
            endcase
        end
    end

    // Combinational so the requester can advance its beat every WRITE cycle;
    // it drops with the asynchronous reset because state does.
    assign bus.wr_data_ack = (state == WRITE);
    assign bus.busy        = (state != IDLE);
    assign state_dbg       = state;

endmodule

// File: tb/tb_dram_port_arbiter.sv
module tb_dram_port_arbiter;

    localparam int BURST_LEN = 4;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 64;

    localparam logic [63:0] DA = 64'hAAAA_0000_0000_0001;
    localparam logic [63:0] DB = 64'hBBBB_0000_0000_0002;
    localparam logic [63:0] DC = 64'hCCCC_0000_0000_0003;
    localparam logic [63:0] DD = 64'hDDDD_0000_0000_0004;
    localparam logic [63:0] DE = 64'hEEEE_0000_0000_0005;

    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;

    int n_checks;
    int n_errors;

    dram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dram_port_arbiter #(
        .BURST_LEN(BURST_LEN),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic              rd_req;
        logic              wr_req;
        logic [ADDR_W-1:0] rd_addr;
        logic [ADDR_W-1:0] wr_addr;
        logic [DATA_W-1:0] wr_data;
        logic              e_rg;
        logic              e_wg;
        logic              e_ack;
        logic              e_rdv;
        logic              e_ren;
        logic              e_wen;
        logic              e_busy;
        logic [ADDR_W-1:0] e_raddr;
        logic [ADDR_W-1:0] e_waddr;
        logic [DATA_W-1:0] e_wdata;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(
        logic rq, logic wq, logic [ADDR_W-1:0] ra, logic [ADDR_W-1:0] wa,
        logic [DATA_W-1:0] wd, logic rg, logic wg, logic ack, logic rdv,
        logic ren, logic wen, logic bsy, logic [ADDR_W-1:0] era,
        logic [ADDR_W-1:0] ewa, logic [DATA_W-1:0] ewd);
        vec_t v;
        v.rd_req = rq;  v.wr_req = wq;  v.rd_addr = ra;  v.wr_addr = wa;
        v.wr_data = wd; v.e_rg = rg;    v.e_wg = wg;     v.e_ack = ack;
        v.e_rdv = rdv;  v.e_ren = ren;  v.e_wen = wen;   v.e_busy = bsy;
        v.e_raddr = era; v.e_waddr = ewa; v.e_wdata = ewd;
        return v;
    endfunction

    // scoreboard helper
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rd_req  = 1'b0;
        bus.wr_req  = 1'b0;
        bus.rd_addr = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    // Runs until IDLE (bounded), then lets trailing read-valid pulses drain.
    task automatic wait_idle(input string name);
        for (int i = 0; i < 50; i++) begin
            if (bus.busy === 1'b0) break;
            step();
        end
        chk({name, " idle_reached"}, 64'(bus.busy), 64'd0);
        step();
        step();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " rd_grant"},      64'(bus.rd_grant),      64'd0);
        chk({name, " wr_grant"},      64'(bus.wr_grant),      64'd0);
        chk({name, " wr_data_ack"},   64'(bus.wr_data_ack),   64'd0);
        chk({name, " rd_data_valid"}, 64'(bus.rd_data_valid), 64'd0);
        chk({name, " mem_ren"},       64'(bus.mem_ren),       64'd0);
        chk({name, " mem_wen"},       64'(bus.mem_wen),       64'd0);
        chk({name, " mem_raddr"},     64'(bus.mem_raddr),     64'd0);
        chk({name, " mem_waddr"},     64'(bus.mem_waddr),     64'd0);
        chk({name, " mem_wdata"},     64'(bus.mem_wdata),     64'd0);
        chk({name, " busy"},          64'(bus.busy),          64'd0);
        chk({name, " state"},         64'(state_dbg),         64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Vectors: inputs applied for one cycle, outputs checked just after
        // the following rising edge.
        // Single read at 0x3FE: addresses wrap through 0x3FF -> 0x000.
        vecs[0]  = mk(1, 0, 10'h3FE, 0, 0,  1, 0, 0, 0, 0, 0, 1, 10'h000, 10'h000, 64'd0);
        vecs[1]  = mk(0, 0, 0, 0, 0,        0, 0, 0, 0, 1, 0, 1, 10'h3FE, 10'h000, 64'd0);
        vecs[2]  = mk(0, 0, 0, 0, 0,        0, 0, 0, 1, 1, 0, 1, 10'h3FF, 10'h000, 64'd0);
        vecs[3]  = mk(0, 0, 0, 0, 0,        0, 0, 0, 1, 1, 0, 1, 10'h000, 10'h000, 64'd0);
        vecs[4]  = mk(0, 0, 0, 0, 0,        0, 0, 0, 1, 1, 0, 0, 10'h001, 10'h000, 64'd0);
        vecs[5]  = mk(0, 0, 0, 0, 0,        0, 0, 0, 1, 0, 0, 0, 10'h001, 10'h000, 64'd0);
        vecs[6]  = mk(0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 10'h001, 10'h000, 64'd0);
        // Single write at 0x010, beats A..D each presented while acked.
        vecs[7]  = mk(0, 1, 0, 10'h010, 0,  0, 1, 1, 0, 0, 0, 1, 10'h001, 10'h000, 64'd0);
        vecs[8]  = mk(0, 0, 0, 0, DA,       0, 0, 1, 0, 0, 1, 1, 10'h001, 10'h010, DA);
        vecs[9]  = mk(0, 0, 0, 0, DB,       0, 0, 1, 0, 0, 1, 1, 10'h001, 10'h011, DB);
        vecs[10] = mk(0, 0, 0, 0, DC,       0, 0, 1, 0, 0, 1, 1, 10'h001, 10'h012, DC);
        vecs[11] = mk(0, 0, 0, 0, DD,       0, 0, 0, 0, 0, 1, 0, 10'h001, 10'h013, DD);
        vecs[12] = mk(0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 10'h001, 10'h013, DD);

        // Reset held low with both requests high: everything stays zero.
        rst = 1'b0;
        bus.rd_req  = 1'b1;
        bus.wr_req  = 1'b1;
        bus.rd_addr = 10'h100;
        bus.wr_addr = 10'h200;
        bus.wr_data = DE;
        step();
        step();
        chk_all_zero("in_reset");
        rst = 1'b1;
        #1;
        chk("release rd_grant_before_edge", 64'(bus.rd_grant), 64'd0);
        step();
        chk("release rd_grant", 64'(bus.rd_grant), 64'd1);
        chk("release wr_grant", 64'(bus.wr_grant), 64'd0);
        chk("release state",    64'(state_dbg),    64'd1);
        idle_inputs();
        wait_idle("release");

        // Table-driven single read and single write.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            bus.rd_req  = vecs[i].rd_req;
            bus.wr_req  = vecs[i].wr_req;
            bus.rd_addr = vecs[i].rd_addr;
            bus.wr_addr = vecs[i].wr_addr;
            bus.wr_data = vecs[i].wr_data;
            step();
            chk($sformatf("v%0d rd_grant", i),      64'(bus.rd_grant),      64'(vecs[i].e_rg));
            chk($sformatf("v%0d wr_grant", i),      64'(bus.wr_grant),      64'(vecs[i].e_wg));
            chk($sformatf("v%0d wr_data_ack", i),   64'(bus.wr_data_ack),   64'(vecs[i].e_ack));
            chk($sformatf("v%0d rd_data_valid", i), 64'(bus.rd_data_valid), 64'(vecs[i].e_rdv));
            chk($sformatf("v%0d mem_ren", i),       64'(bus.mem_ren),       64'(vecs[i].e_ren));
            chk($sformatf("v%0d mem_wen", i),       64'(bus.mem_wen),       64'(vecs[i].e_wen));
            chk($sformatf("v%0d busy", i),          64'(bus.busy),          64'(vecs[i].e_busy));
            chk($sformatf("v%0d mem_raddr", i),     64'(bus.mem_raddr),     64'(vecs[i].e_raddr));
            chk($sformatf("v%0d mem_waddr", i),     64'(bus.mem_waddr),     64'(vecs[i].e_waddr));
            chk($sformatf("v%0d mem_wdata", i),     64'(bus.mem_wdata),     64'(vecs[i].e_wdata));
        end

        // Both requests held: R,W,R,W with one IDLE cycle between bursts.
        // Last grant in the table was a write, so read goes first.
        bus.rd_req  = 1'b1;
        bus.wr_req  = 1'b1;
        bus.rd_addr = 10'h040;
        bus.wr_addr = 10'h080;
        bus.wr_data = DE;
        for (int b = 0; b < 4; b++) begin
            step();
            chk($sformatf("rr%0d rd_grant", b), 64'(bus.rd_grant), 64'((b % 2) == 0));
            chk($sformatf("rr%0d wr_grant", b), 64'(bus.wr_grant), 64'((b % 2) == 1));
            for (int k = 1; k < BURST_LEN; k++) begin
                step();
                chk($sformatf("rr%0d.%0d busy", b, k), 64'(bus.busy), 64'd1);
                chk($sformatf("rr%0d.%0d no_grant", b, k),
                    64'(bus.rd_grant | bus.wr_grant), 64'd0);
                chk($sformatf("rr%0d.%0d ren_wen_excl", b, k),
                    64'(bus.mem_ren & bus.mem_wen), 64'd0);
            end
            step();
            chk($sformatf("rr%0d idle_gap", b), 64'(bus.busy), 64'd0);
            chk($sformatf("rr%0d idle_no_grant", b),
                64'(bus.rd_grant | bus.wr_grant), 64'd0);
        end
        idle_inputs();
        wait_idle("rr");

        // Reset asserted during write beat 2, then a fresh write burst.
        bus.wr_req  = 1'b1;
        bus.wr_addr = 10'h020;
        bus.wr_data = DA;
        step();
        chk("abort wr_grant", 64'(bus.wr_grant), 64'd1);
        step();
        step();
        chk("abort beat2_ack", 64'(bus.wr_data_ack), 64'd1);
        chk("abort beat2_wen_prev", 64'(bus.mem_wen), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("abort mem_wen",     64'(bus.mem_wen),     64'd0);
        chk("abort wr_data_ack", 64'(bus.wr_data_ack), 64'd0);
        chk("abort busy",        64'(bus.busy),        64'd0);
        chk("abort state",       64'(state_dbg),       64'd0);
        bus.wr_addr = 10'h040;
        bus.wr_data = DE;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("restart grant_before_edge", 64'(bus.wr_grant), 64'd0);
        step();
        chk("restart wr_grant", 64'(bus.wr_grant),    64'd1);
        chk("restart ack",      64'(bus.wr_data_ack), 64'd1);
        bus.wr_req = 1'b0;
        step();
        chk("restart mem_wen",   64'(bus.mem_wen),   64'd1);
        chk("restart mem_waddr", 64'(bus.mem_waddr), 64'h040);
        chk("restart mem_wdata", 64'(bus.mem_wdata), DE);
        wait_idle("restart");

        // Write request raised during a read burst waits for IDLE.
        bus.rd_req  = 1'b1;
        bus.rd_addr = 10'h100;
        step();
        chk("defer rd_grant", 64'(bus.rd_grant), 64'd1);
        bus.rd_req  = 1'b0;
        bus.wr_req  = 1'b1;
        bus.wr_addr = 10'h200;
        for (int k = 1; k < BURST_LEN; k++) begin
            step();
            chk($sformatf("defer%0d ack", k),      64'(bus.wr_data_ack), 64'd0);
            chk($sformatf("defer%0d wr_grant", k), 64'(bus.wr_grant),    64'd0);
            chk($sformatf("defer%0d busy", k),     64'(bus.busy),        64'd1);
        end
        step();
        chk("defer idle busy",     64'(bus.busy),        64'd0);
        chk("defer idle ack",      64'(bus.wr_data_ack), 64'd0);
        chk("defer idle wr_grant", 64'(bus.wr_grant),    64'd0);
        step();
        chk("defer wr_grant", 64'(bus.wr_grant),    64'd1);
        chk("defer ack",      64'(bus.wr_data_ack), 64'd1);
        bus.wr_req = 1'b0;
        wait_idle("defer");

        // final report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
